seg_msg_sequencer: RTL and testbench

SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

---
 rtl/seg_msg_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/seg_msg_sequencer.sv | 121 ++++++++++++
 tb/tb_seg_msg_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_msg_pkg.sv
// Shared constants for the segment message sequencer: message length,
// glyph ROM contents and the sequencer FSM state encoding.
package seg_msg_pkg;

  localparam int MSG_LEN  = 14;
  localparam int LAST_IDX = 13;
  localparam int IDX_W    = 4;

  // Glyph patterns as {dp,a,b,c,d,e,f,g}, one per message position
  localparam logic [7:0] GLYPH_ROM [0:MSG_LEN-1] = '{
    8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
    8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Out-of-range indices read as blank rather than wrapping into the table
  function automatic logic [7:0] glyph_at(input logic [IDX_W-1:0] i);
    logic [7:0] g;
    g = 8'h00;
    if (i <= IDX_W'(LAST_IDX)) g = GLYPH_ROM[i];
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce
// counter, and a registered one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          pulse_reg;

  // Bring the raw button into the clk domain through two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b00;
    else        sync_reg <= {sync_reg[0], btn};
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples;
  // pulse only when the accepted level rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        pulse_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/seg_msg_sequencer.sv
// Steps a 14-glyph message out to a seven-segment display, either
// automatically at a programmable rate or one glyph per button press.
module seg_msg_sequencer
  import seg_msg_pkg::*;
#(
  parameter int DIV_BASE   = 1000000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       step_btn,
  input  logic       clr,
  input  logic [1:0] rate_sel,
  output logic [7:0] seg_out,
  output logic [3:0] idx,
  output logic       wrap
);

  // Wide enough for the longest period (DIV_BASE << 3) without overflow
  localparam int PW = $clog2(DIV_BASE * 8 + 1);

  state_t           state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [1:0]       rate_reg, rate_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       seg_reg, seg_next;
  logic             wrap_reg, wrap_next;
  logic [PW-1:0]    term;
  logic             tick;
  logic             advance;
  logic             step_pulse;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // Terminal count uses the rate captured at the last reload, so a rate
  // change only takes effect from the following period
  assign term = (PW'(DIV_BASE) << rate_reg) - PW'(1);
  assign tick = (state_reg == ST_RUN) && (presc_reg == term);

  // State, prescaler and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      rate_reg  <= 2'd0;
      idx_reg   <= '0;
      seg_reg   <= 8'h00;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      rate_reg  <= rate_next;
      idx_reg   <= idx_next;
      seg_reg   <= seg_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next state: clr beats everything, then run_en, then a step press
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run_en)          state_next = ST_RUN;
          else if (step_pulse) state_next = ST_HOLD;
        end
        ST_RUN:  if (!run_en) state_next = ST_HOLD;
        ST_HOLD: if (run_en)  state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Index advance, wrap pulse, displayed glyph and prescaler reload
  always_comb begin
    advance    = 1'b0;
    idx_next   = idx_reg;
    wrap_next  = 1'b0;
    presc_next = '0;
    rate_next  = rate_reg;

    if (!clr) begin
      if (state_reg == ST_RUN && run_en && tick)           advance = 1'b1;
      if (state_reg == ST_HOLD && !run_en && step_pulse)   advance = 1'b1;
    end

    if (advance) begin
      wrap_next = (idx_reg == IDX_W'(LAST_IDX));
      idx_next  = wrap_next ? '0 : idx_reg + 1'b1;
    end

    if (state_next == ST_IDLE) begin
      idx_next  = '0;
      wrap_next = 1'b0;
    end

    seg_next = (state_next == ST_IDLE) ? 8'h00 : glyph_at(idx_next);

    // Count only while staying in RUN; any other case reloads from zero
    if (state_reg == ST_RUN && state_next == ST_RUN && !tick) begin
      presc_next = presc_reg + 1'b1;
    end else begin
      presc_next = '0;
      rate_next  = rate_sel;
    end
  end

  assign seg_out = seg_reg;
  assign idx     = idx_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench for seg_msg_sequencer with DIV_BASE=4, DEB_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_msg_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run_en;
  logic       step_btn;
  logic       clr;
  logic [1:0] rate_sel;
  logic [7:0] seg_out;
  logic [3:0] idx;
  logic       wrap;

  int checks;
  int failures;

  logic [7:0] rom [0:13] = '{
    8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F,
    8'h3E, 8'h0E, 8'h5F, 8'h7E, 8'h15, 8'h3E, 8'h0E
  };

  seg_msg_sequencer #(.DIV_BASE(4), .DEB_CYCLES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_en   (run_en),
    .step_btn (step_btn),
    .clr      (clr),
    .rate_sel (rate_sel),
    .seg_out  (seg_out),
    .idx      (idx),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] s, input logic [3:0] i, input logic w);
    chk({tag, ".seg"},  seg_out,       s);
    chk({tag, ".idx"},  {4'h0, idx},   {4'h0, i});
    chk({tag, ".wrap"}, {7'h0, wrap},  {7'h0, w});
    $display("step %s: seg=0x%02h idx=%0d wrap=%0b", tag, seg_out, idx, wrap);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clean_press();
    step_btn = 1'b1;
    wait_neg(10);
    step_btn = 1'b0;
    wait_neg(8);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    run_en   = 1'b0;
    step_btn = 1'b0;
    clr      = 1'b0;
    rate_sel = 2'd0;

    // Reset state
    wait_neg(2);
    expect_out("reset", 8'h00, 4'd0, 1'b0);
    rst_n = 1'b1;
    wait_neg(1);
    expect_out("idle", 8'h00, 4'd0, 1'b0);

    // Start auto-advance at the base rate
    run_en = 1'b1;
    wait_neg(1);
    expect_out("run_start", 8'h80, 4'd0, 1'b0);
    wait_neg(3);
    expect_out("run_pre1", 8'h80, 4'd0, 1'b0);
    wait_neg(1);
    expect_out("run_idx1", 8'h5B, 4'd1, 1'b0);
    wait_neg(4);
    expect_out("run_idx2", 8'h4F, 4'd2, 1'b0);

    // Walk through the full message and the wrap
    for (int k = 3; k <= 13; k++) begin
      wait_neg(3);
      chk("run_wrap_low", {7'h0, wrap}, 8'h00);
      wait_neg(1);
      expect_out($sformatf("run_idx%0d", k), rom[k], 4'(k), 1'b0);
    end
    wait_neg(3);
    expect_out("run_pre_wrap", 8'h0E, 4'd13, 1'b0);
    wait_neg(1);
    expect_out("run_wrap", 8'h80, 4'd0, 1'b1);
    wait_neg(1);
    expect_out("run_post_wrap", 8'h80, 4'd0, 1'b0);
    wait_neg(3);
    expect_out("run_again1", 8'h5B, 4'd1, 1'b0);

    // Drop run_en on the cycle the tick is due: no advance, then hold
    wait_neg(3);
    run_en = 1'b0;
    wait_neg(1);
    expect_out("hold_tick_blocked", 8'h5B, 4'd1, 1'b0);
    wait_neg(8);
    expect_out("hold_stays", 8'h5B, 4'd1, 1'b0);

    // Two-cycle glitch is rejected
    step_btn = 1'b1;
    wait_neg(2);
    step_btn = 1'b0;
    wait_neg(10);
    expect_out("glitch", 8'h5B, 4'd1, 1'b0);

    // Clean press advances exactly once, 6 cycles after it starts
    step_btn = 1'b1;
    wait_neg(5);
    expect_out("press_t5", 8'h5B, 4'd1, 1'b0);
    wait_neg(1);
    expect_out("press_t6", 8'h4F, 4'd2, 1'b0);
    wait_neg(4);
    step_btn = 1'b0;
    wait_neg(8);
    expect_out("press_once", 8'h4F, 4'd2, 1'b0);

    // Step up to the last glyph, then wrap by hand
    for (int k = 3; k <= 13; k++) begin
      clean_press();
      expect_out($sformatf("hold_idx%0d", k), rom[k], 4'(k), 1'b0);
    end
    step_btn = 1'b1;
    wait_neg(5);
    expect_out("hold_pre_wrap", 8'h0E, 4'd13, 1'b0);
    wait_neg(1);
    expect_out("hold_wrap", 8'h80, 4'd0, 1'b1);
    wait_neg(1);
    expect_out("hold_post_wrap", 8'h80, 4'd0, 1'b0);
    wait_neg(3);
    step_btn = 1'b0;
    wait_neg(8);

    // Resume auto-advance from HOLD, then clear at idx 7
    run_en = 1'b1;
    wait_neg(1);
    expect_out("resume", 8'h80, 4'd0, 1'b0);
    wait_neg(27);
    expect_out("resume_idx6", 8'h5F, 4'd6, 1'b0);
    wait_neg(1);
    expect_out("resume_idx7", 8'h3E, 4'd7, 1'b0);
    clr = 1'b1;
    wait_neg(1);
    expect_out("clr", 8'h00, 4'd0, 1'b0);
    clr    = 1'b0;
    run_en = 1'b0;
    wait_neg(2);
    expect_out("clr_idle", 8'h00, 4'd0, 1'b0);

    // Press from IDLE enters HOLD showing idx 0
    step_btn = 1'b1;
    wait_neg(5);
    expect_out("idle_press_t5", 8'h00, 4'd0, 1'b0);
    wait_neg(1);
    expect_out("idle_to_hold", 8'h80, 4'd0, 1'b0);
    wait_neg(4);
    step_btn = 1'b0;
    wait_neg(8);
    clean_press();
    expect_out("hold_idx1", 8'h5B, 4'd1, 1'b0);

    // Asynchronous reset in the middle of a press
    step_btn = 1'b1;
    wait_neg(4);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 8'h00, 4'd0, 1'b0);
    wait_neg(1);
    step_btn = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(10);
    expect_out("reset_press_lost", 8'h00, 4'd0, 1'b0);

    // Rate change mid-period; a press while running is ignored
    rate_sel = 2'd0;
    run_en   = 1'b1;
    wait_neg(1);
    expect_out("rate_start", 8'h80, 4'd0, 1'b0);
    wait_neg(2);
    rate_sel = 2'd2;
    wait_neg(1);
    expect_out("rate_pre", 8'h80, 4'd0, 1'b0);
    wait_neg(1);
    expect_out("rate_old_period", 8'h5B, 4'd1, 1'b0);
    step_btn = 1'b1;
    wait_neg(10);
    step_btn = 1'b0;
    wait_neg(5);
    expect_out("rate_new_pre", 8'h5B, 4'd1, 1'b0);
    wait_neg(1);
    expect_out("rate_new_period", 8'h4F, 4'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
